checkpoint_profiler: RTL
========================

# checkpoint_profiler

User-project block that consumes the 16-bit checkpoint code firmware drives onto mprj_io[31:16] and measures firmware phases in hardware. It arms on a programmable start marker and stops on a programmable stop marker. Each code change in between is logged as a (code, cycles-since-previous-change) event in a FIFO. The firmware reads the events and the total run length over Wishbone, so cycle counts are available on silicon as well as in simulation.

## Interface
- DEPTH, 16: event FIFO entries (power of two, ≥2)
- CNT_W, 32: width of delta and total counters (≤32)
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- checkbits_i  in  16  checkpoint code (same signal driven to mprj_io[31:16])
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic slave strobes
- wbs_sel_i  in  4  byte selects (writes honour bytes 0–1 only)
- wbs_adr_i  in  32  address; decode uses [4:2] only
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid while ack is high
- irq_o  out  1  high while state==DONE

## Operation
- Register map (word offsets):
  - 0x00 CTRL: [0] enable (RW); [1] clear (W1, self-clearing, reads 0).
  - 0x04 START_MARK[15:0]: RW, reset 0xAB50.
  - 0x08 STOP_MARK[15:0]: RW, reset 0xAB51.
  - 0x0C STATUS (RO): [1:0] state; [2] overflow (sticky); [3] empty; [4] full; [12:8] count.
  - 0x10 EVT_CODE (RO): head code, no pop.
  - 0x14 EVT_DELTA (RO): head delta; the read pops.
  - 0x18 TOTAL (RO): latched run length.
  - 0x1C: reads 0, writes ignored.
- cb_q is checkbits_i registered once. A change is cb_q != cb_prev, where cb_prev is cb_q delayed one more cycle.
- States: IDLE=0, ARMED=1, RUN=2, DONE=3.
  - IDLE → ARMED when enable=1.
  - ARMED → RUN when cb_q==START_MARK. Push (START_MARK, 0). Zero the delta and total counters.
  - In RUN, every cycle: delta+1 and total+1, both saturating at 2^CNT_W−1.
  - RUN, on a change with cb_q!=STOP_MARK: push (cb_q, delta+1), then reset delta to 0.
  - RUN → DONE when cb_q==STOP_MARK. Push (STOP_MARK, delta+1) and latch TOTAL=total+1.
  - DONE holds until clear or enable=0.
  - Any state → IDLE when enable=0. FIFO and TOTAL are retained.
- clear: flushes the FIFO and zeroes overflow, TOTAL and the counters. Next state is ARMED if enable=1 (written in the same access), otherwise IDLE.
- FIFO:
  - Push when full: the event is dropped, overflow is set, and delta still resets.
  - Pop when empty: returns 0 with no side effect.
  - Pop and push in the same cycle while full: both succeed, count unchanged.
  - Pop and push in the same cycle while empty: the push succeeds and the pop returns 0.
- Marker precedence: if START_MARK==STOP_MARK, ARMED → RUN only. DONE is then reached on the next cycle where cb_q equals the marker and is also a change.
- irq_o = (state==DONE). It is not a separate sticky flag.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, state IDLE, FIFO empty, overflow 0, TOTAL 0, CTRL 0.
- Input latency: a checkbits_i edge at cycle t is seen as cb_q at t+1. The resulting state change and push are visible at t+2.
- TOTAL equals the cycle count between checkbits_i becoming START_MARK and checkbits_i becoming STOP_MARK.
- Wishbone:
  - ack_o asserts one cycle after cyc&stb is sampled high with ack_o low, for exactly one cycle. This gives at most one access every 2 cycles.
  - Write effects and the pop take effect on the ack cycle.
  - Read data reflects register state at the cycle the request was sampled.
- Reset mid-run: all state returns to reset values on the next edge, and any in-progress Wishbone ack is cancelled.

## Test plan
- Enable, then drive 0xAB50; 40 cycles later 0x2371; 25 later 0xBF5A; 30 later 0xAB51 -> FIFO holds (AB50,0), (2371,40), (BF5A,25), (AB51,30); TOTAL=95; irq_o=1; STATUS.state=3.
- Leave enable=0 and drive the full marker sequence -> no events, TOTAL=0, irq_o=0. Set enable and replay -> normal capture.
- DEPTH=16, drive 20 changes between the markers without popping -> count=16, overflow=1, first 16 events intact. Each later delta counts from the previous change, including dropped ones.
- Pop while full on the same cycle as a push -> count stays 16, next head correct. Pop when empty -> data 0, count 0.
- Write clear mid-RUN with enable=1 -> FIFO empty, overflow 0, state ARMED; next 0xAB50 restarts the capture.
- Assert wb_rst_i during RUN with ack pending -> ack_o=0 next cycle; START_MARK reads 0xAB50 and STOP_MARK reads 0xAB51.

Source files
------------

// File: rtl/checkpoint_profiler.sv
// Hardware phase profiler: arms on a start checkpoint code, logs (code, delta) events
// into a FIFO until the stop code, and exposes events and run length over Wishbone.
module checkpoint_profiler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] checkbits_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [15:0]      cb_q, cb_prev_q;
  logic [1:0]       state_q, state_d;
  logic             en_q, en_d, ovf_q, ack_q;
  logic [15:0]      start_q, start_d, stop_q, stop_d;
  logic [CNT_W-1:0] delta_q, delta_d, run_q, run_d, total_q, total_d;
  logic [15:0]      code_mem [DEPTH];
  logic [CNT_W-1:0] delta_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [31:0]      dat_q, rdata;

  logic             req, wr_acc, rd_acc, clr, pop, push_req, do_push, ovf_set;
  logic             empty, full, change;
  logic [2:0]       reg_sel;
  logic [15:0]      push_code, head_code;
  logic [CNT_W-1:0] push_delta, head_delta, delta_inc, run_inc;
  logic [31:0]      status;
  logic             unused_ok;

  assign unused_ok = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign reg_sel = wbs_adr_i[4:2];
  assign wr_acc  = req & wbs_we_i;
  assign rd_acc  = req & ~wbs_we_i;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign change     = (cb_q != cb_prev_q);
  assign head_code  = empty ? '0 : code_mem[rd_ptr_q];
  assign head_delta = empty ? '0 : delta_mem[rd_ptr_q];
  assign delta_inc  = (delta_q == CNT_MAX) ? delta_q : delta_q + CNT_W'(1);
  assign run_inc    = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);
  assign status     = {19'd0, 5'(count_q), 3'd0, full, empty, ovf_q, state_q};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0: rdata = {31'd0, en_q};
      3'd1: rdata = {16'd0, start_q};
      3'd2: rdata = {16'd0, stop_q};
      3'd3: rdata = status;
      3'd4: rdata = {16'd0, head_code};
      3'd5: rdata = 32'(head_delta);
      3'd6: rdata = 32'(total_q);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    start_d    = start_q;
    stop_d     = stop_q;
    clr        = 1'b0;
    push_req   = 1'b0;
    push_code  = cb_q;
    push_delta = delta_inc;
    delta_d    = delta_q;
    run_d      = run_q;
    total_d    = total_q;
    if (wr_acc) begin
      case (reg_sel)
        3'd0: if (wbs_sel_i[0]) begin
          en_d = wbs_dat_i[0];
          clr  = wbs_dat_i[1];
        end
        3'd1: begin
          if (wbs_sel_i[0]) start_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) start_d[15:8] = wbs_dat_i[15:8];
        end
        3'd2: begin
          if (wbs_sel_i[0]) stop_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) stop_d[15:8] = wbs_dat_i[15:8];
        end
        default: ;
      endcase
    end
    case (state_q)
      S_IDLE:  if (en_d) state_d = S_ARMED;
      S_ARMED: if (cb_q == start_q) begin
        state_d    = S_RUN;
        push_req   = 1'b1;
        push_code  = start_q;
        push_delta = '0;
        delta_d    = '0;
        run_d      = '0;
      end
      S_RUN: begin
        delta_d = delta_inc;
        run_d   = run_inc;
        // With identical markers the stop must also be a fresh code change.
        if (cb_q == stop_q && (start_q != stop_q || change)) begin
          state_d   = S_DONE;
          push_req  = 1'b1;
          push_code = stop_q;
          total_d   = run_inc;
        end else if (change) begin
          push_req = 1'b1;
          delta_d  = '0;
        end
      end
      default: ;
    endcase
    if (!en_d) begin
      state_d  = S_IDLE;
      push_req = 1'b0;
      delta_d  = delta_q;
      run_d    = run_q;
      total_d  = total_q;
    end
    if (clr) begin
      state_d  = en_d ? S_ARMED : S_IDLE;
      push_req = 1'b0;
      delta_d  = '0;
      run_d    = '0;
      total_d  = '0;
    end
  end

  // A pop and a push on a full FIFO both proceed; only an unmatched full push drops.
  assign pop     = rd_acc && (reg_sel == 3'd5) && !empty;
  assign do_push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_ff @(posedge wb_clk_i) begin
    if (do_push) begin
      code_mem[wr_ptr_q]  <= push_code;
      delta_mem[wr_ptr_q] <= push_delta;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cb_q      <= '0;
      cb_prev_q <= '0;
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      start_q   <= 16'hAB50;
      stop_q    <= 16'hAB51;
      delta_q   <= '0;
      run_q     <= '0;
      total_q   <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      cb_q      <= checkbits_i;
      cb_prev_q <= cb_q;
      state_q   <= state_d;
      en_q      <= en_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      delta_q   <= delta_d;
      run_q     <= run_d;
      total_q   <= total_d;
      ack_q     <= req;
      dat_q     <= rd_acc ? rdata : '0;
      if (clr) begin
        ovf_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (ovf_set) ovf_q <= 1'b1;
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({do_push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = (state_q == S_DONE);
endmodule
